// File: rtl/cla_pkg.sv
// Shared definitions for the 64-bit CLA datapath and the multi-precision sequencer.
package cla_pkg;
  localparam int LIMB_W = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Two's-complement overflow: like-signed operands producing a differently-signed sum.
  function automatic logic limb_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
endpackage

// File: rtl/CLA_64bits.sv
// 64-bit carry-lookahead adder built from 4-bit lookahead blocks; exports group P/G for limb chaining.
module CLA_64bits
  import cla_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W-1:0] s,
  output logic              p,
  output logic              g
);
  localparam int NGRP = LIMB_W / 4;

  logic [LIMB_W-1:0] gen, prop, c;
  logic [NGRP-1:0]   gg, pp;
  logic              cr, cb, gacc;

  always_comb begin
    gen  = a & b;
    prop = a ^ b;
    gg   = '0;
    pp   = '0;
    c    = '0;
    cr   = cin;
    cb   = 1'b0;
    gacc = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      gg[k] = gen[4*k+3] | (prop[4*k+3] & (gen[4*k+2] | (prop[4*k+2] &
              (gen[4*k+1] | (prop[4*k+1] & gen[4*k])))));
      pp[k] = &prop[4*k +: 4];
    end
    // Block carries come from group lookahead; bit carries are resolved inside each block.
    for (int k = 0; k < NGRP; k++) begin
      cb = cr;
      for (int j = 0; j < 4; j++) begin
        c[4*k+j] = cb;
        cb = gen[4*k+j] | (prop[4*k+j] & cb);
      end
      cr   = gg[k] | (pp[k] & cr);
      gacc = gg[k] | (pp[k] & gacc);
    end
    s = prop ^ c;
    p = &pp;
    g = gacc;
  end
endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: one CLA operation per 64-bit limb, LS limb first,
// carry chained between limbs, result limbs streamed out with valid/ready.
module mp_addsub_seq
  import cla_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_op,
  input  logic [LIMB_W-1:0] in_a,
  input  logic [LIMB_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_word,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              busy
);
  localparam int IDX_W = $clog2(NWORDS);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              carry_r, op_r, zacc_r;

  logic              accept, op, cin, last, cout, zacc_nxt, ovf, grp_p, grp_g;
  logic [LIMB_W-1:0] bx, sum;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = (idx != '0);

  // Limb 0 takes its opcode and carry-in straight from the input; later limbs use the latched ones.
  assign op   = (state == S_IDLE) ? in_op : op_r;
  assign cin  = (state == S_IDLE) ? in_op : carry_r;
  assign bx   = in_b ^ {LIMB_W{op}};
  assign last = (idx == IDX_W'(NWORDS - 1));

  CLA_64bits u_cla (
    .a   (in_a),
    .b   (bx),
    .cin (cin),
    .s   (sum),
    .p   (grp_p),
    .g   (grp_g)
  );

  assign cout     = grp_g | (grp_p & cin);
  assign zacc_nxt = ((state == S_IDLE) ? 1'b1 : zacc_r) & (sum == '0);
  assign ovf      = limb_ovf(in_a[LIMB_W-1], bx[LIMB_W-1], sum[LIMB_W-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      carry_r   <= 1'b0;
      op_r      <= OP_ADD;
      zacc_r    <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_word  <= sum;
      out_last  <= last;
      out_cout  <= last & cout;
      out_zero  <= last & zacc_nxt;
      out_ovf   <= last & ovf;
      carry_r   <= cout;
      zacc_r    <= zacc_nxt;
      if (state == S_IDLE) op_r <= in_op;
      if (last) begin
        idx   <= '0;
        state <= S_IDLE;
      end else begin
        idx   <= idx + 1'b1;
        state <= S_RUN;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mp_addsub_seq.sv
// Self-checking bench for mp_addsub_seq: whole-operand arithmetic model, per-cycle output compare.
module tb_mp_addsub_seq;
  localparam int NW = 4;
  localparam int W  = 64 * NW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_op = 1'b0;
  logic [63:0]   in_a = '0;
  logic [63:0]   in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [63:0]   out_word;
  logic          out_last, out_cout, out_zero, out_ovf, busy;

  int checks = 0;
  int errors = 0;
  logic rnd_rdy = 1'b0;

  typedef struct {
    logic [W-1:0] r;
    logic cout, zero, ovf;
  } res_t;

  typedef struct {
    logic [63:0] w;
    logic last, cout, zero, ovf;
  } beat_t;

  beat_t exp_q[$];

  mp_addsub_seq #(.NWORDS(NW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_last(out_last), .out_cout(out_cout), .out_zero(out_zero),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole-operand reference: plain wide arithmetic, signed range check for overflow.
  function automatic res_t compute(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    res_t res;
    logic signed [W:0] sa, sb, full;
    logic [W:0] ua;
    sa = $signed({a[W-1], a});
    sb = $signed({b[W-1], b});
    full = op ? (sa - sb) : (sa + sb);
    ua = {1'b0, a} + {1'b0, b};
    res.r    = full[W-1:0];
    res.cout = op ? (a >= b) : ua[W];
    res.zero = (full[W-1:0] == '0);
    res.ovf  = (full[W] != full[W-1]);
    return res;
  endfunction

  task automatic push_expect(input res_t res);
    beat_t bt;
    for (int i = 0; i < NW; i++) begin
      bt.w    = res.r[64*i +: 64];
      bt.last = (i == NW - 1);
      bt.cout = bt.last ? res.cout : 1'b0;
      bt.zero = bt.last ? res.zero : 1'b0;
      bt.ovf  = bt.last ? res.ovf  : 1'b0;
      exp_q.push_back(bt);
    end
  endtask

  task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input logic op);
    int n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stuck at %0d, required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    in_op = 1'($urandom);
  endtask

  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         input bit gaps, input int nbeats);
    push_expect(compute(a, b, op));
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        go_idle();
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      send_beat(a[64*i +: 64], b[64*i +: 64], (i == 0) ? op : 1'($urandom));
      chk("busy_after_beat", W'(busy), W'(i != NW - 1));
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    for (int i = 0; i < NW; i++) begin
      case ($urandom_range(0, 4))
        0: v[64*i +: 64] = '1;
        1: v[64*i +: 64] = '0;
        2: v[64*i +: 64] = 64'h7FFF_FFFF_FFFF_FFFF;
        default: v[64*i +: 64] = {$urandom, $urandom};
      endcase
    end
    return v;
  endfunction

  always @(posedge clk) begin
    #2;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Output compare: every cycle a limb is taken, plus hold-stability while stalled.
  logic        stall_prev = 1'b0;
  logic [63:0] held_word;
  logic        held_last;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      beat_t e;
      if (stall_prev) begin
        chk("stall_valid", W'(out_valid), W'(1));
        chk("stall_word", W'(out_word), W'(held_word));
        chk("stall_last", W'(out_last), W'(held_last));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", W'(in_ready), W'(0));
      if (!out_valid) chk("idle_in_ready", W'(in_ready), W'(1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got word %0h, required no beat", out_word);
        end else begin
          e = exp_q.pop_front();
          chk("out_word", W'(out_word), W'(e.w));
          chk("out_last", W'(out_last), W'(e.last));
          chk("out_cout", W'(out_cout), W'(e.cout));
          chk("out_zero", W'(out_zero), W'(e.zero));
          chk("out_ovf",  W'(out_ovf),  W'(e.ovf));
        end
      end
      stall_prev = out_valid && !out_ready;
      held_word  = out_word;
      held_last  = out_last;
    end
  end

  initial begin
    res_t r;
    logic [W-1:0] ones, a, b;
    int n;
    ones = '1;

    // Pin the model with hand-computed results.
    r = compute(ones, W'(1), 1'b0);
    chk("pin1_r", r.r, '0);
    chk("pin1_flags", W'({r.cout, r.zero, r.ovf}), W'(3'b110));
    r = compute('0, W'(1), 1'b1);
    chk("pin2_r", r.r, ones);
    chk("pin2_flags", W'({r.cout, r.zero, r.ovf}), W'(3'b000));
    r = compute({64'h7FFF_FFFF_FFFF_FFFF, 192'h0}, {64'h1, 192'h0}, 1'b0);
    chk("pin3_r", r.r, {64'h8000_0000_0000_0000, 192'h0});
    chk("pin3_flags", W'({r.cout, r.zero, r.ovf}), W'(3'b001));
    r = compute(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0);
    chk("pin4_limb1", W'(r.r[127:64]), W'(1));
    r = compute(W'(1), W'(1), 1'b0);
    chk("pin5_r", r.r, W'(2));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_word", W'(out_word), W'(0));
    chk("rst_flags", W'({out_last, out_cout, out_zero, out_ovf}), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    rst = 1'b0;

    send_op(ones, W'(1), 1'b0, 1'b0, NW);
    go_idle();
    send_op('0, W'(1), 1'b1, 1'b0, NW);
    go_idle();
    send_op({64'h7FFF_FFFF_FFFF_FFFF, 192'h0}, {64'h1, 192'h0}, 1'b0, 1'b0, NW);
    go_idle();

    // Backpressure while limb 1 waits behind a held limb 0.
    a = W'(64'hFFFF_FFFF_FFFF_FFFF);
    b = W'(1);
    push_expect(compute(a, b, 1'b0));
    send_beat(a[63:0], b[63:0], 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = a[127:64];
    in_b = b[127:64];
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", W'(in_ready), W'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 1; i < NW; i++) send_beat(a[64*i +: 64], b[64*i +: 64], 1'b1);
    go_idle();
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a subtract, then a fresh add.
    send_op(W'(5), W'(7), 1'b1, 1'b0, 2);
    go_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", W'(out_valid), W'(0));
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_flags", W'({out_last, out_cout, out_zero, out_ovf}), W'(0));
    rst = 1'b0;
    exp_q.delete();
    send_op(W'(1), W'(1), 1'b0, 1'b0, NW);
    go_idle();

    // Back-to-back add then subtract with no gap.
    send_op(rnd_operand(), rnd_operand(), 1'b0, 1'b0, NW);
    send_op(rnd_operand(), rnd_operand(), 1'b1, 1'b0, NW);
    go_idle();

    // Randomised operations with gaps and random backpressure.
    rnd_rdy = 1'b1;
    for (int k = 0; k < 60; k++)
      send_op(rnd_operand(), rnd_operand(), 1'($urandom), 1'b1, NW);
    go_idle();
    @(posedge clk);
    #1;
    rnd_rdy = 1'b0;
    out_ready = 1'b1;

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", W'(exp_q.size()), W'(0));
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mp_addsub_seq.md
# mp_addsub_seq

Multi-precision add/subtract sequencer built around the shared 64-bit CLA datapath. It accepts NWORDS-limb operands as a stream of 64-bit limbs, least-significant limb first, and issues one CLA operation per limb. The carry is chained between limbs from the CLA group propagate/generate outputs. Result limbs stream out with valid/ready backpressure, and the final limb carries the completion flags. It sits between the execute-stage operand buffers and the writeback buffer for wide-integer instructions.

## Interface
- NWORDS, default 4: limbs per operation; range 2–16.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- in_valid  in  1  limb pair present.
- in_ready  out  1  limb pair accepted this cycle when in_valid && in_ready.
- in_op  in  1  0 = add, 1 = subtract (A − B); sampled only on limb 0.
- in_a  in  64  operand A limb.
- in_b  in  64  operand B limb.
- out_valid  out  1  result limb present.
- out_ready  in  1  consumer accepts the result limb.
- out_word  out  64  result limb.
- out_last  out  1  result limb is limb NWORDS−1.
- out_cout  out  1  final carry out; valid with out_last, 0 otherwise. For subtract, 1 = no borrow.
- out_zero  out  1  all NWORDS result limbs are zero; valid with out_last.
- out_ovf  out  1  signed overflow of the full-width result; valid with out_last.
- busy  out  1  an operation is in progress (idx ≠ 0).

## Operation
- FSM has two states:
  - IDLE (idx = 0): the next accepted beat is limb 0. It latches in_op into op_r and uses carry-in = in_op.
  - RUN (1 ≤ idx ≤ NWORDS−1): uses op_r and carry_r. in_op is ignored.
- Per accepted beat:
  - b' = in_b ^ {64{op}}.
  - The CLA computes S = in_a + b' + cin.
  - Limb carry out: cout = G | (P & cin).
  - carry_r ← cout.
  - idx increments. At NWORDS−1 it wraps to 0 and the FSM returns to IDLE.
- Zero accumulator: zacc ← (idx==0 ? 1 : zacc) & (S == 0). out_zero = final zacc.
- Overflow, last limb only: ovf = (in_a[63] == b'[63]) & (S[63] != in_a[63]).
- in_ready = !out_valid || out_ready. This rule is identical in IDLE and RUN, so back-to-back operations need no gap.
- Output register:
  - Loads {S, last, cout, zacc, ovf} on every accepted beat.
  - out_cout, out_zero and out_ovf are forced to 0 when last = 0.
  - out_valid clears when the beat is taken and no new beat is accepted in the same cycle.
- Reset values: out_valid 0, out_word 0, out_last 0, out_cout 0, out_zero 0, out_ovf 0, busy 0, idx 0, carry_r 0, op_r 0. After reset, in_ready = 1.
- Reset mid-operation discards the partial operation and the held result limb with no flags. The next beat is treated as limb 0.
- Simultaneous out handshake and in handshake: the output register is overwritten with the new limb. out_valid stays 1 and nothing is lost.
- in_a/in_b changing while in_valid is low has no effect.

## Timing
- Latency: limb accepted at edge t appears on out_word after edge t, with out_valid high from cycle t+1.
- Throughput: 1 limb/cycle with out_ready held high. One NWORDS-limb operation takes NWORDS cycles.
- The CLA path is combinational within one cycle:
  - input mux → inversion XOR → CLA → output register.
  - No internal pipeline stage.
- A stalled output (out_ready low) holds out_* stable and holds in_ready low the following cycles.

## Structure
- Shared package `cla_pkg`:
  - LIMB_W = 64.
  - Opcode constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - State enum {S_IDLE, S_RUN}.
- One sub-module: `CLA_64bits`, instantiated once, taking (in_a, b', cin) and returning (S, P, G).
- Counter width: $clog2(NWORDS).

## Test plan
All scenarios use NWORDS = 4.
1. Add, A = all-ones (4 limbs 0xFFFF_FFFF_FFFF_FFFF), B = {0,0,0,1} → four limbs 0x0, out_cout = 1, out_zero = 1, out_ovf = 0.
2. Subtract, A = 0, B = 1 → four limbs 0xFFFF_FFFF_FFFF_FFFF, out_cout = 0 (borrow), out_zero = 0, out_ovf = 0.
3. Add, A limb3 = 0x7FFF_FFFF_FFFF_FFFF (others 0), B limb3 = 1 (others 0) → limb3 = 0x8000_0000_0000_0000, out_ovf = 1, out_cout = 0.
4. Backpressure:
   - Stimulus: limb0 = 0xFFFF_FFFF_FFFF_FFFF + 1, then out_ready low for 3 cycles during limb 1.
   - Required: out_word held, in_ready low, no limb dropped, limb1 = 0x1 (carry propagated).
5. Reset after 2 limbs of a subtract, then a full add of 1 + 1 → out limbs {2,0,0,0}. The carry-in is 0, with no stale carry and no stale op.
6. Back-to-back add then subtract with in_valid and out_ready held high:
   - 8 consecutive accepted beats.
   - op switches on beat 4.
   - out_last pulses on beats 3 and 7.
   - busy drops for one cycle only at the wrap.
